adc_spi_read: RTL and testbench
===============================

Name: adc_spi_read

Overview:
- Conversion controller placed directly downstream of the start-pulse edge detector.
- Takes the single-cycle conversion strobe and runs one read frame on a serial SPI-style ADC (CPOL=1, MSB first): chip select, SCLK generation, bit capture.
- Presents the captured word with a one-cycle valid pulse to the acquisition buffer.
- Flags strobes that arrive while a frame is in progress.

Parameters:
- DATA_W, 16: bits per ADC frame; legal range 2..32.
- CLK_DIV, 2: clk cycles per SCLK half-period; minimum 1.
- CS_SETUP, 2: clk cycles from cs_n fall to the first SCLK fall; minimum 1.
- QUIET, 4: clk cycles cs_n is held high after a frame before a new start is accepted; minimum 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion strobe, one clk cycle wide (from the edge detector).
- adc_sdo  in  1  ADC serial data out; sampled directly, timing closed by constraint.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  serial clock; idles high.
- data  out  DATA_W  last complete word, MSB = first bit received.
- data_valid  out  1  one-cycle pulse when data updates.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  one-cycle pulse when start is dropped.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: adc_cs_n=1, adc_sclk=1, data=0, data_valid=0, overrun=0, busy=0, state=IDLE, counters=0.
- Reset mid-frame: takes effect at the next edge. The partial word is discarded and data returns to 0.
- All outputs are registered. busy is decoded from the state register.
- States: IDLE -> SETUP -> SHIFT -> QUIET -> IDLE.
- Edge numbering: E0 is the edge at which start=1 is sampled while state==IDLE.
  - At E0: adc_cs_n<=0, state<=SETUP, cycle counter cleared.
- SETUP:
  - Counts CS_SETUP edges.
  - At E_CS_SETUP: state<=SHIFT, adc_sclk<=0 (first falling edge).
- SHIFT:
  - adc_sclk toggles every CLK_DIV edges.
  - Each rising SCLK edge captures adc_sdo into the shift register in the same clk edge.
  - Bit k (k=0 is MSB) is captured at E(CS_SETUP + CLK_DIV*(2k+1)).
- Final capture edge Ef = E(CS_SETUP + CLK_DIV*(2*DATA_W-1)). At Ef:
  - data<={shift[DATA_W-2:0], adc_sdo}.
  - data_valid<=1 for exactly one cycle.
  - adc_cs_n<=1; adc_sclk stays 1.
  - state<=QUIET.
- Exactly DATA_W rising and DATA_W falling SCLK edges per frame. No SCLK activity outside SHIFT.
- QUIET:
  - Counts QUIET edges, then state<=IDLE at E(f+QUIET).
  - The earliest acceptable start is sampled at E(f+QUIET+1).
- Defaults: Ef=E64, state returns to IDLE at E68, minimum start-to-start period is 69 clk cycles.
- start while state!=IDLE (including the cycle state becomes IDLE): ignored. overrun pulses for one cycle at the following edge. The frame in progress is unaffected.
- data holds its value between frames. data_valid is never asserted without a complete DATA_W-bit frame.
- start held high for several cycles: the first cycle starts a frame. Every later high cycle that falls in a non-IDLE state is counted as an overrun.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SETUP, SHIFT, QUIET};
  - the width helper for the counters (clog2 of the max of CS_SETUP, QUIET, CLK_DIV, DATA_W);
  - the default parameter constants.
- One natural sub-module: adc_sclk_gen. It takes an enable and CLK_DIV and produces adc_sclk plus a one-cycle rise_strobe and fall_strobe.
- Bit counting and the FSM stay in the top level.

Test Plan:
- Reset then a single start, ADC model shifting 16'hA5C3 MSB-first on SCLK fall:
  - adc_cs_n low from E0 to E64;
  - exactly 16 SCLK rises;
  - data=16'hA5C3 and data_valid=1 for one cycle after E64;
  - busy falls after E68.
- Pattern coverage: sdo constant 1 gives data=16'hFFFF; alternating bits give 16'hAAAA. Checks MSB ordering and no off-by-one bit shift.
- start pulses at E10 and at E68 relative to an accepted start: both give an overrun pulse and neither disturbs the frame. A start sampled at E69 is accepted: cs_n falls and a new frame begins.
- rst asserted at E30 mid-SHIFT: next edge gives cs_n=1, sclk=1, busy=0, data=0, with no data_valid. A new start after reset produces a correct full frame.
- Parameter sweep CLK_DIV=1, CS_SETUP=1, QUIET=1, DATA_W=12, with sdo pattern 12'h5A3:
  - SCLK period is 2 clk cycles;
  - Ef=E24;
  - data=12'h5A3;
  - next start accepted at E26.
- start held high for 100 cycles: one frame completes. overrun pulses on every non-IDLE cycle in which start=1. A second frame starts at the first IDLE sample.

Source files
------------

// File: rtl/adc_spi_read_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_read_pkg
// Description : Shared types, default parameter values and the counter-width
//               helper for the serial ADC read controller.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_spi_read_pkg;

    // Default frame geometry
    localparam int c_DEF_DATA_W   = 16;
    localparam int c_DEF_CLK_DIV  = 2;
    localparam int c_DEF_CS_SETUP = 2;
    localparam int c_DEF_QUIET    = 4;

    // Frame controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    // Width of a counter that must reach the largest of the four limits
    // inclusive (the bit counter compares against DATA_W itself).
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_sclk_gen
// Description : Serial clock generator (CPOL=1). A kick forces the first
//               falling edge; while enabled the clock toggles every CLK_DIV
//               cycles; otherwise it idles high. Rise/fall strobes are
//               combinational and coincide with the clk edge that moves SCLK.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sclk_gen
    import adc_spi_read_pkg::*;
#(
    parameter int CLK_DIV = c_DEF_CLK_DIV,
    parameter int CNT_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic en,
    output logic adc_sclk,
    output logic rise_strobe,
    output logic fall_strobe
);

    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic             r_sclk;
    logic             w_wrap;

    assign w_wrap      = en && (r_div_cnt == c_DIV_LAST);
    assign rise_strobe = w_wrap && !r_sclk;
    assign fall_strobe = kick || (w_wrap && r_sclk);
    assign adc_sclk    = r_sclk;

    // Half-period divider and SCLK level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
        end else if (kick) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (en) begin
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_sclk    <= ~r_sclk;
            end else begin
                r_div_cnt <= r_div_cnt + CNT_W'(1);
            end
        end else begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_spi_read.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_read
// Description : Runs one SPI read frame (CPOL=1, MSB first) per accepted
//               start strobe, presents the word with a one-cycle valid pulse
//               and flags strobes that arrive while a frame is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_read
    import adc_spi_read_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int CLK_DIV  = c_DEF_CLK_DIV,
    parameter int CS_SETUP = c_DEF_CS_SETUP,
    parameter int QUIET    = c_DEF_QUIET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int                 c_CNT_W      = cnt_width(CS_SETUP, QUIET, CLK_DIV, DATA_W);
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_QUIET_LAST = c_CNT_W'(QUIET - 1);
    localparam logic [c_CNT_W-1:0] c_BITS       = c_CNT_W'(DATA_W);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_overrun;
    logic                r_cs_n;

    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_CNT_W-1:0]  w_bit_cnt_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_valid_nxt;
    logic                w_overrun_nxt;
    logic                w_cs_n_nxt;

    logic                w_rise;
    logic                w_fall;
    logic                w_setup_done;
    logic                w_quiet_done;
    logic                w_last;
    logic [DATA_W-1:0]   w_word;

    // The bit counter counts SCLK falls, so the rise that follows the
    // DATA_W-th fall carries the last bit of the frame.
    assign w_setup_done = (r_state == ST_SETUP) && (r_cnt == c_SETUP_LAST);
    assign w_quiet_done = (r_state == ST_QUIET) && (r_cnt == c_QUIET_LAST);
    assign w_last       = (r_state == ST_SHIFT) && w_rise && (r_bit_cnt == c_BITS);
    assign w_word       = {r_shift[DATA_W-2:0], adc_sdo};

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (c_CNT_W)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .kick        (w_setup_done),
        .en          (r_state == ST_SHIFT),
        .adc_sclk    (adc_sclk),
        .rise_strobe (w_rise),
        .fall_strobe (w_fall)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)        w_state_nxt = ST_SETUP;
            ST_SETUP: if (w_setup_done) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)       w_state_nxt = ST_QUIET;
            ST_QUIET: if (w_quiet_done) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of counters, shift register and registered outputs
    always_comb begin
        w_cs_n_nxt    = r_cs_n;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_overrun_nxt = start && (r_state != ST_IDLE);
        if (w_fall) w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cs_n_nxt    = 1'b0;
                    w_cnt_nxt     = '0;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_SETUP: begin
                w_cnt_nxt = w_setup_done ? '0 : r_cnt + c_CNT_W'(1);
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    w_shift_nxt = w_word;
                    if (w_last) begin
                        w_data_nxt  = w_word;
                        w_valid_nxt = 1'b1;
                        w_cs_n_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_QUIET: begin
                w_cnt_nxt = w_quiet_done ? '0 : r_cnt + c_CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n    <= 1'b1;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cs_n    <= w_cs_n_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign adc_cs_n   = r_cs_n;
    assign data       = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_read.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_spi_read
// Description : Directed bench for adc_spi_read: default instance (16-bit)
//               and a fast-parameter instance (12-bit, all timings 1).
//               Each run logs DUT outputs per clk edge, numbered from the
//               edge that samples the accepted start (E0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_read;

    localparam int N = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, sdo_a = 1'b0;
    logic        cs_n_a, sclk_a, valid_a, busy_a, ovr_a;
    logic [15:0] data_a;
    logic        start_b = 1'b0, sdo_b = 1'b0;
    logic        cs_n_b, sclk_b, valid_b, busy_b, ovr_b;
    logic [11:0] data_b;

    adc_spi_read #(.DATA_W(16), .CLK_DIV(2), .CS_SETUP(2), .QUIET(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .adc_sdo(sdo_a),
        .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .data(data_a),
        .data_valid(valid_a), .busy(busy_a), .overrun(ovr_a));

    adc_spi_read #(.DATA_W(12), .CLK_DIV(1), .CS_SETUP(1), .QUIET(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .adc_sdo(sdo_b),
        .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .data(data_b),
        .data_valid(valid_b), .busy(busy_b), .overrun(ovr_b));

    // ADC models: next bit (MSB first) presented on each SCLK fall
    logic [15:0] pat_a = 16'h0;
    logic [11:0] pat_b = 12'h0;
    int          idx_a = 0, idx_b = 0;
    always @(negedge cs_n_a) idx_a = 0;
    always @(negedge sclk_a) if (!cs_n_a && idx_a < 16) begin sdo_a = pat_a[15-idx_a]; idx_a++; end
    always @(negedge cs_n_b) idx_b = 0;
    always @(negedge sclk_b) if (!cs_n_b && idx_b < 12) begin sdo_b = pat_b[11-idx_b]; idx_b++; end

    logic        sel = 1'b0;
    logic        cs_log[N], sclk_log[N], valid_log[N], busy_log[N], ovr_log[N];
    logic [15:0] data_log[N];
    logic        start_mask[N];
    int          rst_edge;
    int          n_pass = 0, n_total = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < N; i++) start_mask[i] = 1'b0;
        rst_edge = -1;
    endtask

    task automatic run_edges(input int n);
        for (int e = 0; e < n; e++) begin
            if (sel) start_b = start_mask[e]; else start_a = start_mask[e];
            rst = (e == rst_edge);
            step();
            cs_log[e]    = sel ? cs_n_b  : cs_n_a;
            sclk_log[e]  = sel ? sclk_b  : sclk_a;
            valid_log[e] = sel ? valid_b : valid_a;
            busy_log[e]  = sel ? busy_b  : busy_a;
            ovr_log[e]   = sel ? ovr_b   : ovr_a;
            data_log[e]  = sel ? {4'h0, data_b} : data_a;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b0;
    endtask

    // kind: 0 = SCLK rises, 1 = SCLK falls, 2 = valid cycles, 3 = overrun cycles
    function automatic int count_ev(input int kind, input int lo, input int hi);
        int c = 0;
        for (int e = lo; e <= hi; e++) begin
            case (kind)
                0: if (e > lo && !sclk_log[e-1] && sclk_log[e]) c++;
                1: if (e > lo && sclk_log[e-1] && !sclk_log[e]) c++;
                2: if (valid_log[e]) c++;
                default: if (ovr_log[e]) c++;
            endcase
        end
        return c;
    endfunction

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) step();
        check("rst_cs_n",  cs_n_a,  1);
        check("rst_sclk",  sclk_a,  1);
        check("rst_data",  data_a,  0);
        check("rst_valid", valid_a, 0);
        check("rst_busy",  busy_a,  0);
        check("rst_ovr",   ovr_a,   0);
        check("rst_data_b", data_b, 0);
        rst = 1'b0;
        step();

        // Single frame, 16'hA5C3
        sel = 1'b0; pat_a = 16'hA5C3;
        clear_sched(); start_mask[0] = 1'b1;
        run_edges(75);
        check("a5_cs_low_e0",  cs_log[0], 0);
        check("a5_cs_low_e63", cs_log[63], 0);
        check("a5_cs_high_e64", cs_log[64], 1);
        check("a5_sclk_e1",    sclk_log[1], 1);
        check("a5_sclk_e2",    sclk_log[2], 0);
        check("a5_sclk_e4",    sclk_log[4], 1);
        check("a5_rises",      count_ev(0, 0, 74), 16);
        check("a5_falls",      count_ev(1, 0, 74), 16);
        check("a5_valid_e64",  valid_log[64], 1);
        check("a5_valid_cnt",  count_ev(2, 0, 74), 1);
        check("a5_data",       data_log[64], 16'hA5C3);
        check("a5_data_hold",  data_log[74], 16'hA5C3);
        check("a5_busy_e67",   busy_log[67], 1);
        check("a5_busy_e68",   busy_log[68], 0);
        check("a5_ovr_cnt",    count_ev(3, 0, 74), 0);

        // Constant-one and alternating patterns
        pat_a = 16'hFFFF;
        clear_sched(); start_mask[0] = 1'b1;
        run_edges(70);
        check("ones_data", data_log[64], 16'hFFFF);
        pat_a = 16'hAAAA;
        clear_sched(); start_mask[0] = 1'b1;
        run_edges(70);
        check("alt_data",  data_log[64], 16'hAAAA);
        check("alt_valid", valid_log[64], 1);

        // Overrun at E10 and E68, restart at E69
        pat_a = 16'h1234;
        clear_sched();
        start_mask[0] = 1'b1; start_mask[10] = 1'b1;
        start_mask[68] = 1'b1; start_mask[69] = 1'b1;
        run_edges(140);
        check("ovr_e10",      ovr_log[10], 1);
        check("ovr_e11",      ovr_log[11], 0);
        check("ovr_e68",      ovr_log[68], 1);
        check("ovr_cnt",      count_ev(3, 0, 139), 2);
        check("ovr_rises",    count_ev(0, 0, 68), 16);
        check("ovr_data",     data_log[64], 16'h1234);
        check("ovr_valid",    valid_log[64], 1);
        check("ovr_cs_e68",   cs_log[68], 1);
        check("ovr_cs_e69",   cs_log[69], 0);
        check("ovr_valid2",   valid_log[133], 1);
        check("ovr_data2",    data_log[133], 16'h1234);

        // Reset mid-SHIFT at E30, then a clean frame
        pat_a = 16'hBEEF;
        clear_sched(); start_mask[0] = 1'b1; rst_edge = 30;
        run_edges(50);
        check("mrst_busy_e29", busy_log[29], 1);
        check("mrst_data_e29", data_log[29], 16'h1234);
        check("mrst_cs",       cs_log[30], 1);
        check("mrst_sclk",     sclk_log[30], 1);
        check("mrst_busy",     busy_log[30], 0);
        check("mrst_data",     data_log[30], 0);
        check("mrst_valid",    count_ev(2, 0, 49), 0);
        clear_sched(); start_mask[0] = 1'b1;
        run_edges(70);
        check("mrst_new_data", data_log[64], 16'hBEEF);

        // Fast parameter set, 12'h5A3
        sel = 1'b1; pat_b = 12'h5A3;
        clear_sched(); start_mask[0] = 1'b1; start_mask[26] = 1'b1;
        run_edges(55);
        check("fast_sclk_e1",  sclk_log[1], 0);
        check("fast_sclk_e2",  sclk_log[2], 1);
        check("fast_sclk_e3",  sclk_log[3], 0);
        check("fast_rises",    count_ev(0, 0, 25), 12);
        check("fast_cs_e23",   cs_log[23], 0);
        check("fast_cs_e24",   cs_log[24], 1);
        check("fast_valid",    valid_log[24], 1);
        check("fast_data",     data_log[24], 12'h5A3);
        check("fast_busy_e24", busy_log[24], 1);
        check("fast_busy_e25", busy_log[25], 0);
        check("fast_cs_e26",   cs_log[26], 0);
        check("fast_ovr_cnt",  count_ev(3, 0, 54), 0);
        check("fast_valid2",   valid_log[50], 1);

        // Start held high for 100 cycles
        sel = 1'b0; pat_a = 16'h0F0F;
        clear_sched();
        for (int i = 0; i < 100; i++) start_mask[i] = 1'b1;
        run_edges(140);
        check("hold_ovr_e0",   ovr_log[0], 0);
        check("hold_ovr_e1",   ovr_log[1], 1);
        check("hold_ovr_e69",  ovr_log[69], 0);
        check("hold_ovr_e70",  ovr_log[70], 1);
        check("hold_ovr_e100", ovr_log[100], 0);
        check("hold_ovr_cnt",  count_ev(3, 0, 139), 98);
        check("hold_data",     data_log[64], 16'h0F0F);
        check("hold_cs_e68",   cs_log[68], 1);
        check("hold_cs_e69",   cs_log[69], 0);
        check("hold_valid2",   valid_log[133], 1);
        check("hold_valid_cnt", count_ev(2, 0, 139), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
